ram_dev: RTL and testbench

Device-side responder for the motherboard device bus: the RAM that sits on the far end of the motherboard's `ram_ctrl`/`ram_stat` word pair and the shared `addr`/data bus. It latches a read or write request issued on `ctrl`, waits a configurable access latency, performs the access on an internal word array, and reports completion on `stat`. It holds the completion status until the motherboard withdraws the request, which closes the four-phase handshake.

---
 rtl/ram_dev.sv | 145 ++++++++++++++
 tb/tb_ram_dev.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ram_dev.sv
// ram_dev: device-side RAM responder for the motherboard device bus.
// A request is latched from ctrl in IDLE. After LATENCY cycles the access is
// performed on the internal word array and completion is reported on stat.
// stat is held until the motherboard withdraws ctrl (four-phase handshake).
module ram_dev #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2,
  parameter logic [WORD_WIDTH-1:0] CTRL_READ  = WORD_WIDTH'(16'h0001),
  parameter logic [WORD_WIDTH-1:0] CTRL_WRITE = WORD_WIDTH'(16'h0002),
  parameter logic [WORD_WIDTH-1:0] STAT_IDLE  = WORD_WIDTH'(0),
  parameter logic [WORD_WIDTH-1:0] STAT_BUSY  = WORD_WIDTH'(1),
  parameter logic [WORD_WIDTH-1:0] STAT_DONE  = WORD_WIDTH'(2),
  parameter logic [WORD_WIDTH-1:0] STAT_ERR   = WORD_WIDTH'(3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] ctrl,
  output logic [WORD_WIDTH-1:0] stat,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out
);

  // Index width into the array; the counter only ever holds LATENCY-1 down to 0.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  // One extra bit so DEPTH == 2**WORD_WIDTH still compares correctly.
  localparam logic [WORD_WIDTH:0] DEPTH_LIMIT = (WORD_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    REQ_READ,
    REQ_WRITE,
    REQ_ERR
  } req_t;

  state_t                  state;
  state_t                  state_next;
  req_t                    req_class;
  req_t                    req_decoded;
  logic [CW-1:0]           count;
  logic [AW-1:0]           lat_addr;
  logic [WORD_WIDTH-1:0]   lat_data;
  logic                    in_range;
  logic                    sample;
  logic                    finish;
  logic                    release_req;
  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  // Classify the request presented on ctrl/addr; only used at the sample edge.
  always_comb begin
    in_range    = ({1'b0, addr} < DEPTH_LIMIT);
    req_decoded = REQ_ERR;
    if (in_range && (ctrl == CTRL_READ)) begin
      req_decoded = REQ_READ;
    end else if (in_range && (ctrl == CTRL_WRITE)) begin
      req_decoded = REQ_WRITE;
    end
  end

  // Next-state logic plus one-cycle event strobes for the datapath.
  always_comb begin
    state_next  = state;
    sample      = 1'b0;
    finish      = 1'b0;
    release_req = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl != '0) begin
          state_next = S_BUSY;
          sample     = 1'b1;
        end
      end
      S_BUSY: begin
        if (count == '0) begin
          state_next = S_DONE;
          finish     = 1'b1;
        end
      end
      S_DONE: begin
        if (ctrl == '0) begin
          state_next  = S_IDLE;
          release_req = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, latency counter, status word and read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      req_class <= REQ_ERR;
      lat_addr  <= '0;
      lat_data  <= '0;
      stat      <= STAT_IDLE;
      data_out  <= '0;
    end else begin
      if (sample) begin
        req_class <= req_decoded;
        lat_addr  <= addr[AW-1:0];
        lat_data  <= data_in;
        count     <= CNT_INIT;
        stat      <= STAT_BUSY;
      end else if ((state == S_BUSY) && !finish) begin
        count <= count - 1'b1;
      end
      if (finish) begin
        stat <= (req_class == REQ_ERR) ? STAT_ERR : STAT_DONE;
        if (req_class == REQ_READ) begin
          data_out <= mem[lat_addr];
        end
      end
      if (release_req) begin
        stat <= STAT_IDLE;
      end
    end
  end

  // Array write port; contents survive reset, and an uncommitted write is
  // dropped because reset forces the state away from BUSY.
  always_ff @(posedge clk) begin
    if (finish && (req_class == REQ_WRITE)) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_ram_dev.sv
// tb_ram_dev: three ram_dev instances (LATENCY 2, 1, 5) share one request bus.
// Expected stat/data_out come from transaction timing arithmetic and a word array model.
module tb_ram_dev;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] stat_w [3];
  logic [15:0] dout_w [3];

  int assert_count = 0;
  int fail_count   = 0;

  logic [15:0] model_mem  [DEPTH];
  bit          mem_valid  [DEPTH];
  logic [15:0] exp_dout   [3];
  bit          dout_known [3];

  ram_dev #(.LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .stat(stat_w[0]),
    .addr(addr), .data_in(data_in), .data_out(dout_w[0])
  );

  ram_dev #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .stat(stat_w[1]),
    .addr(addr), .data_in(data_in), .data_out(dout_w[1])
  );

  ram_dev #(.LATENCY(5)) dut_l5 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .stat(stat_w[2]),
    .addr(addr), .data_in(data_in), .data_out(dout_w[2])
  );

  always #5 clk = ~clk;

  function automatic int latOf(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full transaction. rel is the edge (counted from E0) at which ctrl is
  // first sampled as 0; scramble randomises ctrl/addr/data_in while ctrl is held.
  task automatic applyStimulus(input logic [15:0] c, input logic [15:0] a,
                               input logic [15:0] d, input int rel,
                               input bit scramble);
    int          cls;
    int          kmax;
    int          lat;
    logic [15:0] e;
    @(negedge clk);
    ctrl    = c;
    addr    = a;
    data_in = d;
    @(posedge clk);
    if (c == 16'h0001 && int'(a) < DEPTH)      cls = 0;
    else if (c == 16'h0002 && int'(a) < DEPTH) cls = 1;
    else                                       cls = 2;
    kmax = ((rel > 5) ? rel : 5) + 1;
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        lat = latOf(i);
        if (k < lat)                    e = 16'd1;
        else if (k == lat || k < rel)   e = (cls == 2) ? 16'd3 : 16'd2;
        else                            e = 16'd0;
        checkOutput($sformatf("stat L%0d c=%h a=%h k=%0d", lat, c, a, k), stat_w[i], e);
        if (cls == 0 && k == lat) begin
          exp_dout[i]   = model_mem[int'(a)];
          dout_known[i] = mem_valid[int'(a)];
        end
        if (dout_known[i])
          checkOutput($sformatf("data_out L%0d c=%h a=%h k=%0d", lat, c, a, k), dout_w[i], exp_dout[i]);
      end
      if (k + 1 < rel) begin
        if (scramble) begin
          ctrl    = 16'($urandom_range(1, 65535));
          addr    = 16'($urandom);
          data_in = 16'($urandom);
        end else begin
          ctrl = c;
        end
      end else begin
        ctrl = 16'h0000;
      end
    end
    if (cls == 1) begin
      model_mem[int'(a)] = d;
      mem_valid[int'(a)] = 1'b1;
    end
  endtask

  // Asynchronous reset during BUSY of a write: must drop the write.
  task automatic resetDuringWrite(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ctrl    = 16'h0002;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("async reset stat L%0d", latOf(i)), stat_w[i], 16'd0);
      checkOutput($sformatf("async reset data_out L%0d", latOf(i)), dout_w[i], 16'd0);
      exp_dout[i]   = 16'd0;
      dout_known[i] = 1'b1;
    end
    @(negedge clk);
    ctrl = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rc;
    logic [15:0] ra;
    int          sel;
    rst     = 1'b1;
    ctrl    = 16'h0000;
    addr    = 16'h0000;
    data_in = 16'h0000;
    for (int i = 0; i < DEPTH; i++) mem_valid[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_dout[i]   = 16'd0;
      dout_known[i] = 1'b1;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset stat L%0d", latOf(i)), stat_w[i], 16'd0);
      checkOutput($sformatf("reset data_out L%0d", latOf(i)), dout_w[i], 16'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h0002, 16'd5, 16'hBEEF, 3, 1'b0);
    applyStimulus(16'h0001, 16'd5, 16'h0000, 3, 1'b0);
    applyStimulus(16'h0002, 16'd0, 16'h1234, 2, 1'b0);
    applyStimulus(16'h0001, 16'd0, 16'h0000, 6, 1'b0);
    applyStimulus(16'h0002, 16'd1, 16'h5A5A, 3, 1'b0);
    applyStimulus(16'h0003, 16'd1, 16'hFFFF, 3, 1'b0);
    applyStimulus(16'h0001, 16'd1, 16'h0000, 3, 1'b0);
    applyStimulus(16'h0001, 16'd256, 16'h0000, 3, 1'b0);
    applyStimulus(16'h0001, 16'd255, 16'h0000, 3, 1'b0);
    applyStimulus(16'h0001, 16'd5, 16'h0000, 16, 1'b0);
    applyStimulus(16'h0002, 16'd9, 16'h7777, 8, 1'b1);
    applyStimulus(16'h0001, 16'd9, 16'h0000, 2, 1'b0);
    applyStimulus(16'h0002, 16'd10, 16'hA0A0, 1, 1'b0);
    applyStimulus(16'h0001, 16'd10, 16'h0000, 1, 1'b0);
    applyStimulus(16'h0002, 16'd7, 16'h1111, 2, 1'b0);
    resetDuringWrite(16'd7, 16'h2222);
    applyStimulus(16'h0001, 16'd7, 16'h0000, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      rc = 16'h0001;
      else if (sel <= 6) rc = 16'h0002;
      else if (sel == 7) rc = 16'h0003;
      else if (sel == 8) rc = 16'h0004;
      else               rc = 16'h8001;
      sel = $urandom_range(0, 11);
      if (sel < 8)        ra = 16'($urandom_range(0, 15));
      else if (sel == 8)  ra = 16'd255;
      else if (sel == 9)  ra = 16'd256;
      else if (sel == 10) ra = 16'd300;
      else                ra = 16'hFFFF;
      applyStimulus(rc, ra, 16'($urandom), $urandom_range(1, 9),
                    1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
